uc_multiciclo: RTL and testbench
================================

Name: uc_multiciclo

Overview:
- Multicycle successor to the single-cycle control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM states.
- It drives the same datapath controls as the single-cycle unit, plus instruction-register and PC write strobes.
- It adds a parametrised data-memory latency and stack-depth tracking with overflow/underflow trapping.
- It sits between the instruction register (supplies opcode) and the datapath (PC mux, register bank, ALU, stack, data memory).

Parameters:
- STACK_DEPTH, 8: number of return-address stack entries; must be ≥1.
- MEM_LAT, 1: data-memory access cycles for load/store; must be ≥1.
- LVLW, $clog2(STACK_DEPTH+1): width of the sp_level output.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction opcode from the IR; valid from DECODE onward.
- z  in  1  zero flag from the flag register.
- ir_load  out  1  capture instruction memory output into the IR.
- pc_we  out  1  PC register write enable; exactly one cycle per completed instruction.
- s_inc  out  1  PC mux select: 1 = PC+1, 0 = jump target.
- we3  out  1  register bank write enable.
- wez  out  1  zero-flag write enable.
- pop  out  1  stack pop.
- push  out  1  stack push.
- s_stack  out  1  PC source = stack top.
- we4  out  1  data memory write enable.
- s_inm  out  2  register write-data select: 00 = ALU, 01 = immediate, 10 = data memory.
- op_alu  out  3  ALU operation.
- halted  out  1  unit is trapped in ERR.
- err  out  2  trap cause: 00 none, 01 stack overflow, 10 stack underflow, 11 illegal opcode.
- sp_level  out  LVLW  current stack occupancy.

Behaviour:
- Internal registers: state, opcode_q (latched at DECODE), z_q (latched at DECODE), wait counter, stack level, err.
- Outputs are Moore functions of these registers. Any output not listed for a state is 0; s_inm/op_alu default to 0.
- Reset at a clock edge:
  - state=FETCH, level=0, err=00, counter=0.
  - Next cycle: ir_load=1, all other strobes 0, halted=0.
  - Reset mid-instruction (including MEM and ERR) aborts without any write strobe in the following cycle.
- FETCH: ir_load=1 → DECODE.
- DECODE: latch opcode_q/z_q; no strobes. Next state:
  - Illegal opcode (1000xx..1111xx not listed below): → ERR, err=11.
  - 101001 with level==STACK_DEPTH: → ERR, err=01.
  - 101000 with level==0: → ERR, err=10.
  - 1110xx/1111xx: → MEM, counter=MEM_LAT-1.
  - Otherwise: → EXEC.
- EXEC (1 cycle, then → FETCH):
  - pc_we=1 always; s_inc=1 unless stated otherwise.
  - 0xxxxx: we3=1, wez=1, s_inm=00, op_alu=opcode_q[4:2].
  - 1000xx: we3=1, s_inm=01.
  - 100100: s_inc=0; we3=0.
  - 100101: s_inc=!z_q.
  - 100110: s_inc=z_q.
  - 101000 (return): pop=1, s_stack=1, s_inc=0; level decrements.
  - 101001 (call): push=1, s_inc=0; level increments.
- MEM:
  - s_inm=10 held throughout (load) or 00 (store); counter decrements each cycle.
  - Strobes fire only in the cycle counter==0: load: we3=1, pc_we=1; store: we4=1, pc_we=1. Then → FETCH.
  - MEM_LAT=1 means a single MEM cycle.
- ERR: halted=1, err held, all strobes 0, level frozen; exit only via reset.
- Latency: ALU/imm/jump/stack = 3 cycles; load/store = 2+MEM_LAT cycles.
- wez is asserted only for 0xxxxx.
- we3/we4/push/pop/pc_we are never asserted outside EXEC/MEM and never for more than one cycle per instruction.
- level never exceeds STACK_DEPTH and never wraps.

Test Plan:
- Reset, then opcode=000100 (ALU op 001) held → FETCH(ir_load=1), DECODE(all 0), EXEC(we3=1, wez=1, op_alu=001, pc_we=1, s_inc=1), then FETCH; 3-cycle period.
- 100101 with z=1, then with z=0 → EXEC s_inc=0 then s_inc=1; we3=0 and wez=0 in both cases.
- MEM_LAT=3, opcode 111101 → MEM lasts 3 cycles with s_inm=10; we3 and pc_we are high only in the 3rd; 5-cycle total. Opcode 111000 → we4 high once, in the 3rd MEM cycle.
- STACK_DEPTH=2: three consecutive 101001 → sp_level 1, 2, then DECODE of the 3rd goes to ERR with err=01, halted=1, and no push strobe. Reset → sp_level=0, err=00.
- Fresh reset, then 101000 → ERR with err=10. Fresh reset, then 101100 → ERR with err=11. Strobes stay 0 for 10 further cycles.
- Reset asserted during the 2nd MEM cycle of a store (MEM_LAT=3) → we4 never asserts; the next cycle shows ir_load=1.

Source files
------------

// File: rtl/uc_multiciclo_if.sv
// Control bus between the multicycle control unit and the datapath.
//   opcode, z     : from the instruction register and the flag register
//   ir_load..op_alu : datapath strobes and selects
//   halted, err   : trap status
//   sp_level      : current return-stack occupancy (LVLW bits)
// Modports: master = control unit, slave = datapath side.
interface uc_multiciclo_if #(
   parameter int LVLW = 4
);
   logic [5:0]      opcode;
   logic            z;
   logic            ir_load;
   logic            pc_we;
   logic            s_inc;
   logic            we3;
   logic            wez;
   logic            pop;
   logic            push;
   logic            s_stack;
   logic            we4;
   logic [1:0]      s_inm;
   logic [2:0]      op_alu;
   logic            halted;
   logic [1:0]      err;
   logic [LVLW-1:0] sp_level;

   modport master (
      input  opcode, z,
      output ir_load, pc_we, s_inc, we3, wez, pop, push, s_stack, we4,
             s_inm, op_alu, halted, err, sp_level
   );

   modport slave (
      output opcode, z,
      input  ir_load, pc_we, s_inc, we3, wez, pop, push, s_stack, we4,
             s_inm, op_alu, halted, err, sp_level
   );
endinterface

// File: rtl/uc_multiciclo.sv
// Multicycle control unit. Each instruction walks FETCH -> DECODE -> EXEC
// (or MEM for loads/stores) -> FETCH. Stack-depth overflow/underflow and
// illegal opcodes trap into ERR, which is left only through reset.
// Ports:
//   clk       : system clock, rising edge
//   reset     : synchronous, active-high
//   bus       : control bus (master side), see uc_multiciclo_if
//   dbg_state : current FSM state encoding (FETCH=0 DECODE=1 EXEC=2 MEM=3 ERR=4)
// All bus outputs are Moore functions of the internal registers.
module uc_multiciclo #(
   parameter int STACK_DEPTH = 8,
   parameter int MEM_LAT     = 1,
   parameter int LVLW        = $clog2(STACK_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   uc_multiciclo_if.master   bus,
   output logic [2:0]        dbg_state
);

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [5:0] OP_JMP  = 6'b100100;
   localparam logic [5:0] OP_JNZ  = 6'b100101;
   localparam logic [5:0] OP_JZ   = 6'b100110;
   localparam logic [5:0] OP_RET  = 6'b101000;
   localparam logic [5:0] OP_CALL = 6'b101001;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_ERR    = 3'd4
   } state_t;

   state_t          state, state_n;
   logic [5:0]      opcode_q;
   logic            z_q;
   logic [CW-1:0]   cnt;
   logic [LVLW-1:0] level;
   logic [1:0]      err_q, err_n;
   logic            legal;

   // Everything with the top bit clear is an ALU op; 111xxx covers both
   // store (1110xx) and load (1111xx).
   always_comb begin
      legal = 1'b0;
      if (!bus.opcode[5])                     legal = 1'b1;
      else if (bus.opcode[5:2] == 4'b1000)    legal = 1'b1;
      else if (bus.opcode[5:3] == 3'b111)     legal = 1'b1;
      else if (bus.opcode == OP_JMP || bus.opcode == OP_JNZ ||
               bus.opcode == OP_JZ  || bus.opcode == OP_RET ||
               bus.opcode == OP_CALL)         legal = 1'b1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= state_n;
   end

   // Next state and trap cause
   always_comb begin
      state_n = state;
      err_n   = err_q;
      unique case (state)
         S_FETCH:  state_n = S_DECODE;
         S_DECODE: begin
            if (!legal) begin
               state_n = S_ERR;
               err_n   = 2'b11;
            end else if (bus.opcode == OP_CALL && level == LVLW'(STACK_DEPTH)) begin
               state_n = S_ERR;
               err_n   = 2'b01;
            end else if (bus.opcode == OP_RET && level == '0) begin
               state_n = S_ERR;
               err_n   = 2'b10;
            end else if (bus.opcode[5:3] == 3'b111) begin
               state_n = S_MEM;
            end else begin
               state_n = S_EXEC;
            end
         end
         S_EXEC:   state_n = S_FETCH;
         S_MEM:    if (cnt == '0) state_n = S_FETCH;
         S_ERR:    state_n = S_ERR;
         default:  state_n = S_FETCH;
      endcase
   end

   // Datapath registers: latched opcode/flag, wait counter, stack level, err
   always_ff @(posedge clk) begin
      if (reset) begin
         opcode_q <= '0;
         z_q      <= 1'b0;
         cnt      <= '0;
         level    <= '0;
         err_q    <= 2'b00;
      end else begin
         err_q <= err_n;
         if (state == S_DECODE) begin
            opcode_q <= bus.opcode;
            z_q      <= bus.z;
            cnt      <= CW'(MEM_LAT - 1);
         end
         if (state == S_MEM && cnt != '0)
            cnt <= cnt - 1'b1;
         // Bounds were checked in DECODE, so these never wrap.
         if (state == S_EXEC && opcode_q == OP_CALL)
            level <= level + 1'b1;
         else if (state == S_EXEC && opcode_q == OP_RET)
            level <= level - 1'b1;
      end
   end

   // Moore outputs
   always_comb begin
      bus.ir_load = 1'b0;
      bus.pc_we   = 1'b0;
      bus.s_inc   = 1'b0;
      bus.we3     = 1'b0;
      bus.wez     = 1'b0;
      bus.pop     = 1'b0;
      bus.push    = 1'b0;
      bus.s_stack = 1'b0;
      bus.we4     = 1'b0;
      bus.s_inm   = 2'b00;
      bus.op_alu  = 3'b000;
      bus.halted  = 1'b0;
      unique case (state)
         S_FETCH: bus.ir_load = 1'b1;
         S_EXEC: begin
            bus.pc_we = 1'b1;
            bus.s_inc = 1'b1;
            if (!opcode_q[5]) begin
               bus.we3    = 1'b1;
               bus.wez    = 1'b1;
               bus.op_alu = opcode_q[4:2];
            end else if (opcode_q[5:2] == 4'b1000) begin
               bus.we3   = 1'b1;
               bus.s_inm = 2'b01;
            end else if (opcode_q == OP_JMP) begin
               bus.s_inc = 1'b0;
            end else if (opcode_q == OP_JNZ) begin
               bus.s_inc = !z_q;
            end else if (opcode_q == OP_JZ) begin
               bus.s_inc = z_q;
            end else if (opcode_q == OP_RET) begin
               bus.pop     = 1'b1;
               bus.s_stack = 1'b1;
               bus.s_inc   = 1'b0;
            end else if (opcode_q == OP_CALL) begin
               bus.push  = 1'b1;
               bus.s_inc = 1'b0;
            end
         end
         S_MEM: begin
            // opcode_q[2] separates load (1111xx) from store (1110xx)
            bus.s_inm = opcode_q[2] ? 2'b10 : 2'b00;
            if (cnt == '0) begin
               bus.pc_we = 1'b1;
               if (opcode_q[2]) bus.we3 = 1'b1;
               else             bus.we4 = 1'b1;
            end
         end
         S_ERR: bus.halted = 1'b1;
         default: ;
      endcase
   end

   assign bus.err      = err_q;
   assign bus.sp_level = level;
   assign dbg_state    = state;

endmodule

// File: tb/tb_uc_multiciclo.sv
module tb_uc_multiciclo;

   // Packed view of all controls:
   // {ir_load,pc_we,s_inc,we3,wez,pop,push,s_stack,we4,s_inm[1:0],op_alu[2:0],halted,err[1:0]}
   localparam logic [16:0] IR    = 17'h1_0000;
   localparam logic [16:0] PCW   = 17'h0_8000;
   localparam logic [16:0] SINC  = 17'h0_4000;
   localparam logic [16:0] WE3   = 17'h0_2000;
   localparam logic [16:0] WEZ   = 17'h0_1000;
   localparam logic [16:0] POP   = 17'h0_0800;
   localparam logic [16:0] PUSH  = 17'h0_0400;
   localparam logic [16:0] SSTK  = 17'h0_0200;
   localparam logic [16:0] WE4   = 17'h0_0100;
   localparam logic [16:0] SIM01 = 17'h0_0040;
   localparam logic [16:0] SIM10 = 17'h0_0080;
   localparam logic [16:0] ALU1  = 17'h0_0008;
   localparam logic [16:0] ERR01 = 17'h0_0005;
   localparam logic [16:0] ERR10 = 17'h0_0006;
   localparam logic [16:0] ERR11 = 17'h0_0007;
   localparam logic [16:0] NONE  = 17'h0_0000;

   logic        clk;
   logic        reset;
   logic [2:0]  dbg_state;
   logic [16:0] obs;
   int          errors;
   int          checks;

   uc_multiciclo_if #(.LVLW(2)) bus ();

   uc_multiciclo #(.STACK_DEPTH(2), .MEM_LAT(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   assign obs = {bus.ir_load, bus.pc_we, bus.s_inc, bus.we3, bus.wez,
                 bus.pop, bus.push, bus.s_stack, bus.we4, bus.s_inm,
                 bus.op_alu, bus.halted, bus.err};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [16:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_sp(input string tag, input logic [1:0] exp);
      checks++;
      assert (bus.sp_level === exp) else begin
         errors++;
         $error("FAIL %s: sp_level observed=%0d expected=%0d", tag, bus.sp_level, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      errors     = 0;
      checks     = 0;
      reset      = 1'b1;
      bus.opcode = 6'b000100;
      bus.z      = 1'b0;
      tick();
      do_reset();

      // Reset state
      chk("reset_fetch", IR);
      chk_sp("reset_sp", 2'd0);

      // ALU op 001, 3-cycle period
      tick(); chk("alu_decode", NONE);
      tick(); chk("alu_exec", PCW | SINC | WE3 | WEZ | ALU1);
      tick(); chk("alu_fetch", IR);

      // Conditional 100101: z=1 then z=0
      bus.opcode = 6'b100101; bus.z = 1'b1;
      tick(); chk("jnz_z1_decode", NONE);
      tick(); chk("jnz_z1_exec", PCW);
      tick(); chk("jnz_z1_fetch", IR);
      bus.z = 1'b0;
      tick(); tick(); chk("jnz_z0_exec", PCW | SINC);
      tick();

      // Immediate load 1000xx
      bus.opcode = 6'b100010;
      tick(); tick(); chk("imm_exec", PCW | SINC | WE3 | SIM01);
      tick();

      // Unconditional jump and 100110 with z=1
      bus.opcode = 6'b100100;
      tick(); tick(); chk("jmp_exec", PCW);
      tick();
      bus.opcode = 6'b100110; bus.z = 1'b1;
      tick(); tick(); chk("jz_z1_exec", PCW | SINC);
      tick();

      // Load 111101, MEM_LAT=3: 5-cycle instruction
      bus.opcode = 6'b111101;
      tick(); chk("ld_decode", NONE);
      tick(); chk("ld_mem1", SIM10);
      tick(); chk("ld_mem2", SIM10);
      tick(); chk("ld_mem3", SIM10 | WE3 | PCW);
      tick(); chk("ld_fetch", IR);

      // Store 111000
      bus.opcode = 6'b111000;
      tick(); tick(); chk("st_mem1", NONE);
      tick(); chk("st_mem2", NONE);
      tick(); chk("st_mem3", WE4 | PCW);
      tick(); chk("st_fetch", IR);

      // Calls up to STACK_DEPTH=2, third traps with overflow
      bus.opcode = 6'b101001;
      tick(); tick(); chk("call1_exec", PUSH | PCW);
      tick(); chk_sp("call1_sp", 2'd1);
      tick(); tick(); chk("call2_exec", PUSH | PCW);
      tick(); chk_sp("call2_sp", 2'd2);
      tick(); tick(); chk("call3_err", ERR01);
      chk_sp("call3_sp_frozen", 2'd2);
      tick(); tick(); chk("call3_err_held", ERR01);
      do_reset();
      chk("ovf_reset_fetch", IR);
      chk_sp("ovf_reset_sp", 2'd0);

      // Call then return, then underflow on a second return
      tick(); tick(); tick();
      chk_sp("call_ret_sp1", 2'd1);
      bus.opcode = 6'b101000;
      tick(); tick(); chk("ret_exec", POP | SSTK | PCW);
      tick(); chk_sp("ret_sp0", 2'd0);
      tick(); tick(); chk("ret_underflow", ERR10);

      // Fresh reset, underflow directly
      do_reset();
      tick(); tick(); chk("fresh_underflow", ERR10);

      // Fresh reset, illegal opcode, then 10 quiet cycles
      do_reset();
      bus.opcode = 6'b101100;
      tick(); tick(); chk("illegal_err", ERR11);
      for (int i = 0; i < 10; i++) begin
         tick(); chk("illegal_held", ERR11);
      end

      // Reset during 2nd MEM cycle of a store
      do_reset();
      bus.opcode = 6'b111000;
      tick(); tick(); chk("abort_mem1", NONE);
      tick(); chk("abort_mem2", NONE);
      reset = 1'b1;
      tick(); chk("abort_fetch", IR);
      reset = 1'b0;
      tick(); chk("abort_decode", NONE);
      tick(); chk("abort_new_mem1", NONE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
